// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the registered priority request encoder.
// Imported by the interface, the picker and the top.
package prio_enc_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Index width for n request lines; never narrower than one bit.
  function automatic int enc_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_req_encoder_if.sv
// Output handshake bundle of prio_req_encoder.
// The encoder drives the master side, the consumer the slave side.
interface prio_req_encoder_if
  import prio_enc_pkg::*;
#(
  parameter int N = 8
);

  localparam int W = enc_w(N);

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;

  modport master (
    output out_valid,
    output out_idx,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    output out_ready
  );

endinterface

// File: rtl/prio_pick.sv
// Combinational picker: highest set bit, or first set bit
// searching upward from start with wrap at N-1.
module prio_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  input  logic         rr,
  output logic         any,
  output logic [W-1:0] idx
);

  int s;
  int d;
  int best;

  // Each set bit gets a distance; the smallest distance wins.
  always_comb begin
    idx  = '0;
    s    = int'(start);
    d    = 0;
    best = N;
    for (int i = 0; i < N; i++) begin
      if (rr) begin
        d = (i >= s) ? (i - s) : (i + N - s);
      end else begin
        d = N - 1 - i;
      end
      if (vec[i] && (d < best)) begin
        best = d;
        idx  = W'(i);
      end
    end
  end

  assign any = |vec;

endmodule

// File: rtl/prio_req_encoder.sv
// Sticky request capture with one pending index presented
// at a time on a valid/ready port, fixed or round-robin order.
module prio_req_encoder
  import prio_enc_pkg::*;
#(
  parameter int N       = 8,
  parameter int RR_MODE = MODE_FIXED
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N-1:0]         req,
  prio_req_encoder_if.master   out,
  output logic [N-1:0]         pending,
  output logic                 merged
);

  localparam int W     = enc_w(N);
  localparam bit IS_RR = (RR_MODE == MODE_RR);

  logic [N-1:0] pending_q, pending_d;
  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic         merged_q, merged_d;

  logic         served;
  logic         load;
  logic [N-1:0] served_mask;
  logic [N-1:0] cand;
  logic [N-1:0] req_g;
  logic         pick_any;
  logic [W-1:0] pick_idx;

  assign served      = valid_q & out.out_ready;
  assign served_mask = {{(N-1){1'b0}}, served} << idx_q;
  assign cand        = pending_q & ~served_mask;
  assign req_g       = en ? req : '0;
  assign load        = ~valid_q | served;

  // Candidates exclude this cycle's requests: one cycle of latency.
  prio_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .vec   (cand),
    .start (ptr_q),
    .rr    (IS_RR),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  assign pending_d = cand | req_g;
  assign merged_d  = |(req_g & cand);

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    unique case (1'b1)
      !load: begin
        valid_d = valid_q;
        idx_d   = idx_q;
      end
      load && pick_any: begin
        valid_d = 1'b1;
        idx_d   = pick_idx;
      end
      load && !pick_any: begin
        valid_d = 1'b0;
        idx_d   = '0;
      end
      default: begin
        valid_d = valid_q;
        idx_d   = idx_q;
      end
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (IS_RR && served) begin
      ptr_d = (idx_q == W'(N - 1)) ? '0 : idx_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      ptr_q     <= '0;
      merged_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      merged_q  <= merged_d;
    end
  end

  assign out.out_valid = valid_q;
  assign out.out_idx   = idx_q;
  assign pending       = pending_q;
  assign merged        = merged_q;

endmodule
